// File: rtl/bbox_detect_overlay.sv
// Bounding-box detector and outline overlay sink for the 64x64 video stream.
// Measures each frame's object box and draws the previous frame's box, 2 clk latency.
module bbox_detect_overlay #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int COORD_W = 11,
  parameter int THRESH  = 128,
  parameter int BOX_R   = 255,
  parameter int BOX_G   = 0,
  parameter int BOX_B   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [7:0]         r_in,
  input  logic [7:0]         g_in,
  input  logic [7:0]         b_in,
  output logic               de_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic [7:0]         r_out,
  output logic [7:0]         g_out,
  output logic [7:0]         b_out,
  output logic [COORD_W-1:0] bbox_xmin,
  output logic [COORD_W-1:0] bbox_xmax,
  output logic [COORD_W-1:0] bbox_ymin,
  output logic [COORD_W-1:0] bbox_ymax,
  output logic               bbox_valid,
  output logic               frame_done
);

  localparam logic [7:0] THR = 8'(THRESH);
  localparam logic [7:0] BXR = 8'(BOX_R);
  localparam logic [7:0] BXG = 8'(BOX_G);
  localparam logic [7:0] BXB = 8'(BOX_B);
  localparam logic [COORD_W-1:0] CMAX = '1;

  logic               de_q;
  logic               vs_q;
  logic               synced;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               vs_rise;
  logic               de_fall;
  logic               hit;
  logic               frame_end;

  logic [COORD_W-1:0] acc_xmin;
  logic [COORD_W-1:0] acc_xmax;
  logic [COORD_W-1:0] acc_ymin;
  logic [COORD_W-1:0] acc_ymax;
  logic               acc_found;

  logic               ol;
  logic               de1;
  logic               hs1;
  logic               vs1;
  logic               ol1;
  logic [7:0]         r1;
  logic [7:0]         g1;
  logic [7:0]         b1;

  assign vs_rise   = vs_in & ~vs_q;
  assign de_fall   = ~de_in & de_q;
  assign frame_end = vs_rise & synced;
  // a pixel coinciding with the vsync edge belongs to no frame
  assign hit       = synced & de_in & ~vs_rise & (r_in >= THR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q   <= 1'b0;
      vs_q   <= 1'b0;
      synced <= 1'b0;
    end else begin
      de_q <= de_in;
      vs_q <= vs_in;
      if (vs_rise) synced <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (vs_rise) begin
      x <= '0;
      y <= '0;
    end else if (de_fall) begin
      x <= '0;
      if (y != CMAX) y <= y + 1'b1;
    end else if (de_in && x != CMAX) begin
      x <= x + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_xmin  <= '0;
      acc_xmax  <= '0;
      acc_ymin  <= '0;
      acc_ymax  <= '0;
      acc_found <= 1'b0;
    end else if (vs_rise) begin
      acc_xmin  <= '1;
      acc_xmax  <= '0;
      acc_ymin  <= '1;
      acc_ymax  <= '0;
      acc_found <= 1'b0;
    end else if (hit) begin
      if (!acc_found || x < acc_xmin) acc_xmin <= x;
      if (!acc_found || x > acc_xmax) acc_xmax <= x;
      if (!acc_found || y < acc_ymin) acc_ymin <= y;
      if (!acc_found || y > acc_ymax) acc_ymax <= y;
      acc_found <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_xmin  <= '0;
      bbox_xmax  <= '0;
      bbox_ymin  <= '0;
      bbox_ymax  <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        bbox_valid <= acc_found;
        bbox_xmin  <= acc_found ? acc_xmin : '0;
        bbox_xmax  <= acc_found ? acc_xmax : '0;
        bbox_ymin  <= acc_found ? acc_ymin : '0;
        bbox_ymax  <= acc_found ? acc_ymax : '0;
      end
    end
  end

  always_comb begin
    ol = 1'b0;
    if (bbox_valid && de_in) begin
      if ((x == bbox_xmin || x == bbox_xmax) &&
          y >= bbox_ymin && y <= bbox_ymax)
        ol = 1'b1;
      if ((y == bbox_ymin || y == bbox_ymax) &&
          x >= bbox_xmin && x <= bbox_xmax)
        ol = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      ol1 <= 1'b0;
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
    end else begin
      de1 <= de_in;
      hs1 <= hs_in;
      vs1 <= vs_in;
      ol1 <= ol;
      r1  <= r_in;
      g1  <= g_in;
      b1  <= b_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out <= 1'b0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else begin
      de_out <= de1;
      hs_out <= hs1;
      vs_out <= vs1;
      if (!de1) begin
        r_out <= '0;
        g_out <= '0;
        b_out <= '0;
      end else if (ol1) begin
        r_out <= BXR;
        g_out <= BXG;
        b_out <= BXB;
      end else begin
        r_out <= r1;
        g_out <= g1;
        b_out <= b1;
      end
    end
  end

endmodule

// File: tb/tb_bbox_detect_overlay.sv
// Directed frame-table bench for bbox_detect_overlay.
// Drives whole frames and predicts every output cycle from its own model.
module tb_bbox_detect_overlay;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        de_in = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic [7:0]  r_in = '0;
  logic [7:0]  g_in = '0;
  logic [7:0]  b_in = '0;
  logic        de_out, hs_out, vs_out;
  logic [7:0]  r_out, g_out, b_out;
  logic [10:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic        bbox_valid, frame_done;

  always #5 clk = ~clk;

  bbox_detect_overlay dut (
    .clk(clk), .rst_n(rst_n),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
    .bbox_valid(bbox_valid), .frame_done(frame_done)
  );

  typedef struct {
    int          kind;
    logic [10:0] xmin, xmax, ymin, ymax;
    logic        valid;
    int          boxpix;
  } vec_t;

  vec_t tbl[8];

  int    vecs = 0;
  int    errs = 0;
  int    stream_err = 0;
  string first_msg = "";
  int    box_cnt = 0;
  int    fd_cnt = 0;

  logic [2:0]  p0_sync = '0, p1_sync = '0;
  logic [23:0] p0_rgb = '0, p1_rgb = '0;
  bit          p0_chk = 0, p1_chk = 0;
  bit          fd_pend = 0;
  bit          mvs_prev = 0;
  bit          msynced = 0;
  bit          eb_valid = 0;
  int          eb_xmin = 0, eb_xmax = 0, eb_ymin = 0, eb_ymax = 0;

  function automatic logic [7:0] pix(int kind, int x, int y);
    case (kind)
      1: return (x == 10 && y == 20) ? 8'd255 : 8'd0;
      2: return (x >= 5 && x <= 40 && y >= 3 && y <= 50) ? 8'd200 : 8'd0;
      3: return ((x == 0 && y == 0) || (x == 63 && y == 63)) ? 8'd128 : 8'd0;
      4: return ((x == 0 && y == 0) || (x == 63 && y == 63)) ? 8'd127 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  function automatic bit outline(int x, int y);
    bit v, h;
    v = (x == eb_xmin || x == eb_xmax) && y >= eb_ymin && y <= eb_ymax;
    h = (y == eb_ymin || y == eb_ymax) && x >= eb_xmin && x <= eb_xmax;
    return eb_valid && (v || h);
  endfunction

  task automatic check(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_stream(input string name);
    vecs++;
    if (stream_err != 0) begin
      errs++;
      $display("FAIL %s stream: %0d bad cycles, first %s",
               name, stream_err, first_msg);
    end
    stream_err = 0;
  endtask

  task automatic note(input string what, input logic [23:0] act,
                      input logic [23:0] exp);
    stream_err++;
    if (stream_err == 1)
      first_msg = $sformatf("%s @%0t got %0h want %0h", what, $time, act, exp);
  endtask

  task automatic tick(input logic de, input logic hs, input logic vs,
                      input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input int x, input int y,
                      input bit chk);
    logic [23:0] e;
    @(negedge clk);
    if ({de_out, hs_out, vs_out} !== p1_sync)
      note("de/hs/vs", {21'd0, de_out, hs_out, vs_out}, {21'd0, p1_sync});
    if (p1_chk && {r_out, g_out, b_out} !== p1_rgb)
      note("rgb", {r_out, g_out, b_out}, p1_rgb);
    if (frame_done !== fd_pend)
      note("frame_done", {23'd0, frame_done}, {23'd0, fd_pend});
    if (de_out === 1'b1 && {r_out, g_out, b_out} === 24'hFF0000) box_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    p1_sync = p0_sync;
    p1_rgb  = p0_rgb;
    p1_chk  = p0_chk;
    if (!de) e = '0;
    else if (outline(x, y)) e = 24'hFF0000;
    else e = {r, g, b};
    p0_sync = {de, hs, vs};
    p0_rgb  = e;
    p0_chk  = chk;
    fd_pend = 0;
    if (vs && !mvs_prev) begin
      fd_pend = msynced;
      msynced = 1;
    end
    mvs_prev = vs;
    de_in = de; hs_in = hs; vs_in = vs;
    r_in = r; g_in = g; b_in = b;
  endtask

  task automatic frame(input int kind, input int nl);
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < 64; x++)
        tick(1, 0, 0, pix(kind, x, y), 8'(x + 1), 8'(y), x, y, 1);
      tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic vsync();
    tick(0, 0, 1, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset(input string name);
    #2 rst_n = 1'b0;
    #1;
    check({name, " video outs"},
          {de_out, hs_out, vs_out, r_out, g_out, b_out}, '0);
    check({name, " bbox outs"},
          {frame_done, bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
          '0);
    de_in = 0; hs_in = 0; vs_in = 0;
    r_in = 0; g_in = 0; b_in = 0;
    p0_sync = '0; p1_sync = '0; p0_rgb = '0; p1_rgb = '0;
    p0_chk = 0; p1_chk = 0; fd_pend = 0;
    mvs_prev = 0; msynced = 0; eb_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_eb(input vec_t v);
    eb_valid = v.valid;
    eb_xmin = int'(v.xmin); eb_xmax = int'(v.xmax);
    eb_ymin = int'(v.ymin); eb_ymax = int'(v.ymax);
  endtask

  initial begin
    int   fd0;
    vec_t v;
    tbl[0] = '{1, 11'd10, 11'd10, 11'd20, 11'd20, 1'b1, 0};
    tbl[1] = '{0, 11'd0,  11'd0,  11'd0,  11'd0,  1'b0, 1};
    tbl[2] = '{2, 11'd5,  11'd40, 11'd3,  11'd50, 1'b1, 0};
    tbl[3] = '{2, 11'd5,  11'd40, 11'd3,  11'd50, 1'b1, 164};
    tbl[4] = '{0, 11'd0,  11'd0,  11'd0,  11'd0,  1'b0, 164};
    tbl[5] = '{3, 11'd0,  11'd63, 11'd0,  11'd63, 1'b1, 0};
    tbl[6] = '{4, 11'd0,  11'd0,  11'd0,  11'd0,  1'b0, 252};
    tbl[7] = '{2, 11'd5,  11'd40, 11'd3,  11'd50, 1'b1, 0};

    do_reset("power-on reset");

    // bright frame before any vsync must be ignored
    fd0 = fd_cnt;
    frame(2, 64);
    vsync();
    check("first vsync no pulse", fd_cnt - fd0, 0);
    check("bbox after sync",
          {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, '0);
    check_stream("presync");

    foreach (tbl[i]) begin
      v = tbl[i];
      box_cnt = 0;
      fd0 = fd_cnt;
      frame(v.kind, 64);
      set_eb(v);
      vsync();
      check($sformatf("vec%0d bbox", i),
            {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
            {v.valid, v.xmin, v.xmax, v.ymin, v.ymax});
      check($sformatf("vec%0d frame_done pulses", i), fd_cnt - fd0, 1);
      check($sformatf("vec%0d outline pixels", i), box_cnt, v.boxpix);
      check_stream($sformatf("vec%0d", i));
    end

    // reset in the middle of a frame with a valid box showing
    frame(2, 30);
    for (int x = 0; x < 10; x++)
      tick(1, 0, 0, pix(2, x, 30), 8'(x + 1), 8'd30, x, 30, 1);
    check_stream("pre-reset");
    do_reset("mid-frame reset");
    fd0 = fd_cnt;
    frame(1, 5);
    vsync();
    check("resync no pulse", fd_cnt - fd0, 0);
    check("bbox after resync",
          {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, '0);
    fd0 = fd_cnt;
    frame(1, 64);
    set_eb(tbl[0]);
    vsync();
    check("post-reset bbox",
          {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
          {1'b1, 11'd10, 11'd10, 11'd20, 11'd20});
    check("post-reset frame_done pulses", fd_cnt - fd0, 1);
    check_stream("post-reset");

    // random sync pattern: only delay and frame_done are predicted
    repeat (400)
      tick(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
           8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_stream("random sync");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
